conv_tap_sequencer: RTL

Control sequencer for the LeNet5 convolution MAC datapath. On a start pulse it walks a KxK kernel over an IMG_W x IMG_H input feature map (stride 1, no padding), issuing one feature-map read address and one weight address per cycle. It delays first-tap, tap-valid and last-tap markers through a shift line matched to the datapath's register-stage latency, so the accumulator is cleared, enabled and sampled on the correct cycles. It sits between the layer controller (start/done) and the multiplier/accumulator register pipeline.

---
 rtl/lenet_ctrl_pkg.sv | 23 ++
 rtl/conv_marker_line.sv | 27 ++
 rtl/conv_tap_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/lenet_ctrl_pkg.sv
// Shared control types for the LeNet5 conv sequencer: FSM state, marker record,
// default geometry.
package lenet_ctrl_pkg;

  localparam int LENET_IMG_W  = 32;
  localparam int LENET_K      = 5;
  localparam int MARK_COORD_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_e;

  typedef struct packed {
    logic                    valid;
    logic                    first;
    logic                    last;
    logic [MARK_COORD_W-1:0] ox;
    logic [MARK_COORD_W-1:0] oy;
  } marker_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_marker_line.sv
// DEPTH-stage shift line for tap markers; every stage holds while en is low.
module conv_marker_line
  import lenet_ctrl_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    en,
  input  marker_t d,
  output marker_t q
);

  marker_t stage_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (en) begin
      stage_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/conv_tap_sequencer.sv
// KxK stride-1 kernel walker for the conv MAC datapath with latency-matched
// accumulator markers. Optional CONV_SEQ_PERF_CNT_EN adds busy/stall counters.
module conv_tap_sequencer
  import lenet_ctrl_pkg::*;
#(
  parameter int IMG_W    = LENET_IMG_W,
  parameter int IMG_H    = LENET_IMG_W,
  parameter int K        = LENET_K,
  parameter int PIPE_LAT = 3,
  parameter int ADDR_W   = $clog2(IMG_W*IMG_H),
  parameter int WADDR_W  = $clog2(K*K)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             stall,
  output logic                             busy,
  output logic                             done,
  output logic [ADDR_W-1:0]                in_addr,
  output logic [WADDR_W-1:0]               w_addr,
  output logic                             tap_valid,
  output logic                             acc_en,
  output logic                             acc_clr,
  output logic                             out_valid,
  output logic [$clog2(IMG_H-K+1)-1:0]     out_row,
  output logic [$clog2(IMG_W-K+1)-1:0]     out_col
`ifdef CONV_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]                      perf_cycles,
  output logic [31:0]                      perf_stalls
`endif
);

  localparam int OW    = IMG_W - K + 1;
  localparam int OH    = IMG_H - K + 1;
  localparam int KW    = clog2_min1(K);
  localparam int OXW   = clog2_min1(OW);
  localparam int OYW   = clog2_min1(OH);
  localparam int DW    = clog2_min1(PIPE_LAT + 1);
  localparam int ROW_W = $clog2(OH);
  localparam int COL_W = $clog2(OW);

  localparam logic [KW-1:0]  K_MAX     = KW'(K - 1);
  localparam logic [OXW-1:0] OX_MAX    = OXW'(OW - 1);
  localparam logic [OYW-1:0] OY_MAX    = OYW'(OH - 1);
  localparam logic [DW-1:0]  DRAIN_MAX = DW'(PIPE_LAT);

  seq_state_e     state_q, state_d;
  logic [KW-1:0]  kx_q, kx_d, ky_q, ky_d;
  logic [OXW-1:0] ox_q, ox_d;
  logic [OYW-1:0] oy_q, oy_d;
  logic [DW-1:0]  drain_q, drain_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      kx_q    <= '0;
      ky_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      drain_q <= drain_d;
    end
  end

  // kx innermost, then ky, ox, oy; the final wrap returns every counter to 0.
  always_comb begin
    state_d = state_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: if (!stall) begin
        if (kx_q != K_MAX) kx_d = kx_q + 1'b1;
        else begin
          kx_d = '0;
          if (ky_q != K_MAX) ky_d = ky_q + 1'b1;
          else begin
            ky_d = '0;
            if (ox_q != OX_MAX) ox_d = ox_q + 1'b1;
            else begin
              ox_d = '0;
              if (oy_q != OY_MAX) oy_d = oy_q + 1'b1;
              else begin
                oy_d    = '0;
                drain_d = '0;
                state_d = DRAIN;
              end
            end
          end
        end
      end
      DRAIN: if (!stall) begin
        if (drain_q == DRAIN_MAX) state_d = DONE;
        else drain_d = drain_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign tap_valid = (state_q == RUN) && !stall;
  assign in_addr   = ADDR_W'((32'(oy_q) + 32'(ky_q)) * IMG_W + 32'(ox_q) + 32'(kx_q));
  assign w_addr    = WADDR_W'(32'(ky_q) * K + 32'(kx_q));

  marker_t mark_in, tail;

  always_comb begin
    mark_in       = '0;
    mark_in.valid = tap_valid;
    mark_in.first = (kx_q == '0) && (ky_q == '0);
    mark_in.last  = (kx_q == K_MAX) && (ky_q == K_MAX);
    mark_in.ox    = MARK_COORD_W'(ox_q);
    mark_in.oy    = MARK_COORD_W'(oy_q);
  end

  conv_marker_line #(.DEPTH(PIPE_LAT)) u_line (
    .clk   (clk),
    .reset (reset),
    .en    (!stall),
    .d     (mark_in),
    .q     (tail)
  );

  assign acc_en  = tail.valid && !stall;
  assign acc_clr = tail.first && acc_en;

  logic             out_valid_q;
  logic [ROW_W-1:0] out_row_q;
  logic [COL_W-1:0] out_col_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      out_valid_q <= tail.last && acc_en;
      if (tail.last && acc_en) begin
        out_row_q <= tail.oy[ROW_W-1:0];
        out_col_q <= tail.ox[COL_W-1:0];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;

  // Coordinate fields are wider than the output ports.
  logic unused_tail_hi;
  assign unused_tail_hi = ^{tail.ox, tail.oy};

`ifdef CONV_SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles_q, perf_stalls_q;

  // The accept cycle is counted so the total spans start through done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else if (state_q == IDLE && start) begin
      perf_cycles_q <= 32'd1;
      perf_stalls_q <= '0;
    end else if (busy) begin
      if (perf_cycles_q != '1) perf_cycles_q <= perf_cycles_q + 1'b1;
      if (stall && perf_stalls_q != '1) perf_stalls_q <= perf_stalls_q + 1'b1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule
